// File: rtl/reg_delay_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_delay_ctrl_if
// Handshake and status bundle for the register delay-line controller.
//
// Handshake rule (both ends of the pipe): a word moves across a boundary on a
// rising clock edge only when valid and ready are both high in the cycle
// before that edge. A valid word is held stable until it is taken. Ready may
// depend combinationally on the opposite-side ready (never on valid).
//
// Signals
//   in_valid / in_ready    upstream word present / controller accepts it
//   out_valid / out_ready  last stage live / downstream takes it
//   stage_en   [DEPTH]     load enable for each external data register
//   flush                  synchronous clear of every valid bit
//   drain                  request to stop accepting and empty the pipe
//   drain_done             one-cycle pulse when a drain completes
//   occ        [CNT_WIDTH] registered count of live stages
//   busy                   controller is not idle
//   dbg_state  [2]         FSM state (0 idle, 1 active, 2 drain)
//   dbg_valid  [DEPTH]     per-stage valid vector
//
// Modports
//   slave  : the controller itself
//   master : the surrounding datapath / environment
// ---------------------------------------------------------------------------
interface reg_delay_ctrl_if #(
  parameter int DEPTH     = 3,
  parameter int CNT_WIDTH = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [DEPTH-1:0]     stage_en;
  logic                 flush;
  logic                 drain;
  logic                 drain_done;
  logic [CNT_WIDTH-1:0] occ;
  logic                 busy;
  logic [1:0]           dbg_state;
  logic [DEPTH-1:0]     dbg_valid;

  modport slave (
    input  in_valid, out_ready, flush, drain,
    output in_ready, out_valid, stage_en, drain_done, occ, busy,
           dbg_state, dbg_valid
  );

  modport master (
    output in_valid, out_ready, flush, drain,
    input  in_ready, out_valid, stage_en, drain_done, occ, busy,
           dbg_state, dbg_valid
  );
endinterface

// File: rtl/reg_delay_ctrl.sv
// ---------------------------------------------------------------------------
// reg_delay_ctrl
// Valid/ready controller for a DEPTH-stage register delay line. The data
// registers live in the datapath: stage k loads from stage k-1 (stage 0 from
// the input word) whenever stage_en[k] is high. This block tracks one valid
// bit per stage so bubbles collapse toward the output and back-pressure
// stalls exactly the stages that cannot move. It also supports flush and a
// drain sequence, and reports a registered occupancy count.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all state immediately
//   bus    reg_delay_ctrl_if.slave (handshake, enables, status, debug)
// ---------------------------------------------------------------------------
module reg_delay_ctrl #(
  parameter int DEPTH     = 3,
  parameter int CNT_WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  reg_delay_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [DEPTH-1:0]     v;
  logic [DEPTH-1:0]     v_next;
  logic [DEPTH-1:0]     rdy;
  logic [CNT_WIDTH-1:0] occ_q;
  logic [CNT_WIDTH-1:0] occ_next;
  logic                 drain_q;
  logic                 drain_rise;
  logic                 drain_done_q;
  logic                 done_next;
  logic                 accept;

  // Drain is edge-detected so a request held high after completion does not
  // start a second drain.
  assign drain_rise = bus.drain & ~drain_q;

  // Ready chain from the output backwards: a stage can load if it is empty
  // or the stage after it is moving this cycle. Built with a running
  // accumulator so the vector never feeds back on itself.
  always_comb begin
    logic acc;
    rdy = '0;
    acc = bus.out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc    = ~v[k] | acc;
      rdy[k] = acc;
    end
  end

  assign bus.stage_en = rdy & {DEPTH{~bus.flush}};

  // Input is also refused in the cycle a drain is requested, so the pipe
  // starts shrinking immediately rather than one cycle later.
  assign bus.in_ready = rdy[0] & ~bus.flush & (state != DRAIN) & ~drain_rise;
  assign accept       = bus.in_valid & bus.in_ready;

  // Next valid vector: enabled stages shift, stalled stages hold.
  always_comb begin
    v_next = v;
    if (bus.flush) begin
      v_next = '0;
    end else begin
      if (rdy[0]) v_next[0] = accept;
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) v_next[k] = v[k-1];
      end
    end
  end

  // Occupancy is the popcount of the next valid vector, so it is exact and
  // bounded by DEPTH.
  always_comb begin
    occ_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_next = occ_next + CNT_WIDTH'(v_next[k]);
    end
  end

  // FSM next state and drain completion. Flush wins over drain; a flush
  // during (or together with) a drain counts as completing it.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (bus.flush) begin
      state_next = IDLE;
      done_next  = (state == DRAIN) | drain_rise;
    end else if (drain_rise && (state != DRAIN)) begin
      if (v_next == '0) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end else begin
        state_next = DRAIN;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (v_next != '0) state_next = ACTIVE;
        end
        ACTIVE: begin
          if (v_next == '0) state_next = IDLE;
        end
        DRAIN: begin
          if (v_next == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      v            <= '0;
      occ_q        <= '0;
      drain_q      <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state        <= state_next;
      v            <= v_next;
      occ_q        <= occ_next;
      drain_q      <= bus.drain;
      drain_done_q <= done_next;
    end
  end

  assign bus.out_valid  = v[DEPTH-1];
  assign bus.occ        = occ_q;
  assign bus.busy       = (state != IDLE);
  assign bus.drain_done = drain_done_q;
  assign bus.dbg_state  = state;
  assign bus.dbg_valid  = v;

endmodule

// File: tb/tb_reg_delay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_delay_ctrl
// Directed bench for reg_delay_ctrl with DEPTH=3. A small datapath model
// moves 8-bit words through three registers under stage_en; a scoreboard
// queue holds the words accepted at the input and is popped on every output
// transfer.
// ---------------------------------------------------------------------------
module tb_reg_delay_ctrl;
  localparam int DEPTH     = 3;
  localparam int CNT_WIDTH = 2;

  logic       clk;
  logic       reset;
  logic [7:0] in_word;
  logic [7:0] data_r [DEPTH];
  logic [7:0] exp_q [$];

  int total;
  int bad;
  int n_out;

  reg_delay_ctrl_if #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  reg_delay_ctrl #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- datapath model ----------------
  always @(posedge clk) begin
    if (bus.stage_en[0]) data_r[0] <= in_word;
    for (int k = 1; k < DEPTH; k++) begin
      if (bus.stage_en[k]) data_r[k] <= data_r[k-1];
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [7:0] w, input logic ordy,
                       input logic fl, input logic dr);
    bus.in_valid  = iv;
    in_word       = w;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.drain     = dr;
    #1;
  endtask

  // Scoreboard bookkeeping for the current cycle, then advance one edge.
  task automatic tick();
    if (bus.out_valid && bus.out_ready) begin
      check("sb_has_word", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_data", data_r[DEPTH-1], exp_q.pop_front());
      n_out++;
    end
    if (bus.in_valid && bus.in_ready) exp_q.push_back(in_word);
    if (bus.flush) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  int occ_tab  [8] = '{1, 2, 3, 3, 3, 2, 1, 0};
  int oval_tab [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
  int busy_tab [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    total = 0;
    bad   = 0;
    n_out = 0;
    reset = 1'b1;
    drive(0, 8'h00, 0, 0, 0);
    #10;

    // ---- reset state ----
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_occ", bus.occ, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_drain_done", bus.drain_done, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_stage_en", bus.stage_en, 3'b111);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ---- streaming: words 1..5, out_ready high ----
    n_out = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i < 5, 8'(i + 1), 1, 0, 0);
      if (i < 5) check("stream_in_ready", bus.in_ready, 1);
      tick();
      check($sformatf("stream_occ_%0d", i), bus.occ, occ_tab[i]);
      check($sformatf("stream_out_valid_%0d", i), bus.out_valid, oval_tab[i]);
      check($sformatf("stream_busy_%0d", i), bus.busy, busy_tab[i]);
    end
    check("stream_n_out", n_out, 5);

    // ---- back-pressure ----
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'h11 + i), 0, 0, 0);
      tick();
    end
    check("bp_fill_occ", bus.occ, 3);
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h14, 0, 0, 0);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_stage_en", bus.stage_en, 3'b000);
      tick();
      check("bp_occ", bus.occ, 3);
    end
    drive(1, 8'h14, 1, 0, 0);
    check("bp_rel_in_ready", bus.in_ready, 1);
    check("bp_rel_stage_en", bus.stage_en, 3'b111);
    tick();
    check("bp_rel_occ", bus.occ, 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      check("bp_drain_out_valid", bus.out_valid, 1);
      tick();
      check("bp_drain_occ", bus.occ, 2 - i);
    end

    // ---- bubble collapse ----
    drive(1, 8'h21, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 0, 0); tick();
    drive(1, 8'h22, 0, 0, 0); tick();
    check("bub_v_gap", bus.dbg_valid, 3'b101);
    drive(0, 8'h00, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 0, 0);
    check("bub_stage_en", bus.stage_en, 3'b001);
    tick();
    drive(0, 8'h00, 0, 0, 0); tick();
    check("bub_v", bus.dbg_valid, 3'b110);
    check("bub_occ", bus.occ, 2);
    check("bub_tail_word", data_r[2], 8'h21);
    check("bub_next_word", data_r[1], 8'h22);
    drive(0, 8'h00, 1, 0, 0); tick();
    check("bub_rel_occ1", bus.occ, 1);
    drive(0, 8'h00, 1, 0, 0); tick();
    check("bub_rel_occ0", bus.occ, 0);

    // ---- flush ----
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'h31 + i), 0, 0, 0);
      tick();
    end
    check("fl_pre_occ", bus.occ, 3);
    drive(1, 8'h34, 0, 1, 0);
    check("fl_in_ready", bus.in_ready, 0);
    check("fl_stage_en", bus.stage_en, 3'b000);
    tick();
    check("fl_occ", bus.occ, 0);
    check("fl_out_valid", bus.out_valid, 0);
    check("fl_state", bus.dbg_state, 2'd0);
    check("fl_v", bus.dbg_valid, 3'b000);
    drive(0, 8'h00, 1, 0, 0); tick();
    check("fl_not_captured", bus.occ, 0);

    // ---- drain from ACTIVE ----
    drive(1, 8'h41, 1, 0, 0); tick();
    drive(1, 8'h42, 1, 0, 0); tick();
    drive(0, 8'h00, 1, 0, 0); tick();
    check("dr_pre_occ", bus.occ, 2);
    drive(1, 8'h45, 1, 0, 1);
    check("dr_in_ready0", bus.in_ready, 0);
    tick();
    check("dr_occ1", bus.occ, 1);
    check("dr_done0", bus.drain_done, 0);
    check("dr_state", bus.dbg_state, 2'd2);
    drive(1, 8'h45, 1, 0, 1);
    check("dr_in_ready1", bus.in_ready, 0);
    tick();
    check("dr_occ0", bus.occ, 0);
    check("dr_done1", bus.drain_done, 1);
    check("dr_busy", bus.busy, 0);
    drive(0, 8'h00, 1, 0, 1); tick();
    check("dr_held_no_pulse_a", bus.drain_done, 0);
    drive(0, 8'h00, 1, 0, 1); tick();
    check("dr_held_no_pulse_b", bus.drain_done, 0);
    drive(0, 8'h00, 1, 0, 0); tick();

    // ---- drain from IDLE ----
    drive(0, 8'h00, 1, 0, 1); tick();
    check("dri_done", bus.drain_done, 1);
    check("dri_busy", bus.busy, 0);
    drive(0, 8'h00, 1, 0, 0); tick();
    check("dri_done_clear", bus.drain_done, 0);

    // ---- flush and drain together ----
    drive(1, 8'h71, 0, 0, 0); tick();
    check("fd_pre_occ", bus.occ, 1);
    drive(1, 8'h72, 0, 1, 1);
    check("fd_in_ready", bus.in_ready, 0);
    tick();
    check("fd_done", bus.drain_done, 1);
    check("fd_occ", bus.occ, 0);
    check("fd_busy", bus.busy, 0);
    drive(0, 8'h00, 0, 0, 0); tick();
    check("fd_done_clear", bus.drain_done, 0);

    // ---- asynchronous reset mid-stream ----
    drive(1, 8'h51, 1, 0, 0); tick();
    drive(1, 8'h52, 1, 0, 0); tick();
    check("ar_pre_occ", bus.occ, 2);
    drive(0, 8'h00, 1, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("ar_out_valid", bus.out_valid, 0);
    check("ar_occ", bus.occ, 0);
    check("ar_v", bus.dbg_valid, 3'b000);
    exp_q.delete();
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 8'h61, 1, 0, 0);
    check("ar_in_ready", bus.in_ready, 1);
    tick();
    check("ar_lat_e0", bus.out_valid, 0);
    drive(0, 8'h00, 1, 0, 0); tick();
    check("ar_lat_e1", bus.out_valid, 0);
    drive(0, 8'h00, 1, 0, 0); tick();
    check("ar_lat_e2", bus.out_valid, 1);
    check("ar_word", data_r[2], 8'h61);
    drive(0, 8'h00, 1, 0, 0); tick();
    check("ar_empty", bus.occ, 0);

    check("sb_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
